// File: rtl/led_pkg.sv
// led_pkg: shared state encoding, mode constants and helpers for the LED activity array
package led_pkg;
  typedef enum logic [1:0] {LED_IDLE, LED_ON, LED_GAP} led_state_t;
  localparam logic LED_MODE_STRETCH = 1'b0;
  localparam logic LED_MODE_BLINK = 1'b1;
  function automatic longint unsigned led_max(input longint unsigned a, input longint unsigned b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/led_activity_array_if.sv
// led_activity_array_if: channel inputs, global controls and LED drive bundle
interface led_activity_array_if #(parameter int N_CH = 4);
  logic [N_CH-1:0] in;
  logic [N_CH-1:0] mode;
  logic enable;
  logic lamp_test;
  logic [N_CH-1:0] out;
  modport master(output in, mode, enable, lamp_test, input out);
  modport slave(input in, mode, enable, lamp_test, output out);
endinterface

// File: rtl/led_channel.sv
// led_channel: synchroniser, edge detect and STRETCH/BLINK pulse FSM for one LED
module led_channel
  import led_pkg::*;
#(
  parameter int HIGH_TIME = 1_500_000,
  parameter int MIN_OFF = 250_000,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic in,
  input  logic mode,
  input  logic enable,
  output logic on
);
  logic s1, s2, s2_d, ev;
  logic md, md_n, pend, pend_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  led_state_t st, st_n;
  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(HIGH_TIME - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(MIN_OFF - 1);
  assign ev = s2 & ~s2_d;
  // next-state is exported so the top output register sees ON on the same edge the FSM enters it
  assign on = st_n == LED_ON;
  // next-state: disable wins, otherwise mode-dependent hold/blink sequencing
  always_comb begin
    st_n = st;
    cnt_n = cnt;
    pend_n = pend;
    md_n = md;
    if (!enable) begin
      st_n = LED_IDLE;
      cnt_n = '0;
      pend_n = 1'b0;
    end else begin
      case (st)
        LED_IDLE: if (ev) begin
          st_n = LED_ON;
          cnt_n = HI_LOAD;
          md_n = mode;
        end
        LED_ON: if (md == LED_MODE_STRETCH) begin
          st_n = (!ev && cnt == '0) ? LED_IDLE : LED_ON;
          cnt_n = ev ? HI_LOAD : (cnt == '0 ? cnt : cnt - CNT_W'(1));
        end else begin
          pend_n = pend | ev;
          st_n = cnt == '0 ? LED_GAP : LED_ON;
          cnt_n = cnt == '0 ? OFF_LOAD : cnt - CNT_W'(1);
        end
        LED_GAP: if (cnt == '0) begin
          st_n = (pend | ev) ? LED_ON : LED_IDLE;
          cnt_n = (pend | ev) ? HI_LOAD : '0;
          pend_n = 1'b0;
        end else begin
          pend_n = pend | ev;
          cnt_n = cnt - CNT_W'(1);
        end
        default: begin
          st_n = LED_IDLE;
          cnt_n = '0;
          pend_n = 1'b0;
        end
      endcase
    end
  end
  // synchroniser, edge register and FSM state; sync path runs regardless of enable
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s2_d <= 1'b0;
      st <= LED_IDLE;
      cnt <= '0;
      pend <= 1'b0;
      md <= LED_MODE_STRETCH;
    end else begin
      s1 <= in;
      s2 <= s1;
      s2_d <= s2;
      st <= st_n;
      cnt <= cnt_n;
      pend <= pend_n;
      md <= md_n;
    end
  end
endmodule

// File: rtl/led_activity_array.sv
// led_activity_array: N_CH independent LED pulse stretchers with global enable and lamp test
module led_activity_array
  import led_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int HIGH_TIME = 1_500_000,
  parameter int MIN_OFF = 250_000,
  parameter int CNT_W = 32
) (
  input logic clk,
  input logic reset_n,
  led_activity_array_if.slave bus
);
  logic [N_CH-1:0] on, out_q;
  if ((led_max(longint'(HIGH_TIME), longint'(MIN_OFF)) >> CNT_W) != 0) begin : g_bad_cnt_w
    $error("CNT_W too small for HIGH_TIME/MIN_OFF");
  end
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    led_channel #(.HIGH_TIME(HIGH_TIME), .MIN_OFF(MIN_OFF), .CNT_W(CNT_W)) u_ch (
      .clk(clk),
      .reset_n(reset_n),
      .in(bus.in[i]),
      .mode(bus.mode[i]),
      .enable(bus.enable),
      .on(on[i])
    );
  end
  // LED output register; lamp test forces every LED on, even while disabled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) out_q <= '0;
    else out_q <= on | {N_CH{bus.lamp_test}};
  end
  assign bus.out = out_q;
endmodule

// File: tb/tb_led_activity_array.sv
// tb_led_activity_array: directed-vector bench for the LED activity array
module tb_led_activity_array;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  led_activity_array_if #(.N_CH(4)) bus ();
  led_activity_array #(.N_CH(4), .HIGH_TIME(10), .MIN_OFF(4), .CNT_W(32)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s: out=%h expected %h", tag, got, want);
    end
  endtask

  function automatic logic [63:0] win(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int k = lo; k <= hi; k++) m[k] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] bt(input int k);
    logic [63:0] m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // cycle j drives ev/md/en/lt, then checks out after the following edge
  task automatic run_seq(input string tag, input int ch, input int n, input logic [63:0] ev,
                         input logic [63:0] md, input logic [63:0] en, input logic [63:0] lt,
                         input logic [63:0] exp);
    logic [3:0] want;
    for (int j = 0; j < n; j++) begin
      bus.in[ch] = ev[j];
      bus.mode[ch] = md[j];
      bus.enable = en[j];
      bus.lamp_test = lt[j];
      step();
      want = (exp[j] ? 4'(1 << ch) : 4'h0) | (lt[j] ? 4'hF : 4'h0);
      check($sformatf("%s[%0d]", tag, j), bus.out, want);
    end
    bus.in[ch] = 1'b0;
    bus.enable = 1'b1;
    bus.lamp_test = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.in = '0;
    repeat (n) step();
  endtask

  initial begin
    logic [63:0] ones;
    ones = '1;
    bus.in = 4'hF;
    bus.mode = 4'h0;
    bus.enable = 1'b1;
    bus.lamp_test = 1'b0;
    repeat (3) step();
    check("reset", bus.out, 4'h0);
    reset_n = 1'b1;
    for (int j = 1; j <= 16; j++) begin
      step();
      check($sformatf("rel_high[%0d]", j), bus.out, (j >= 3 && j <= 12) ? 4'hF : 4'h0);
    end
    idle(6);
    check("rel_idle", bus.out, 4'h0);

    run_seq("stretch_retrig", 0, 22, bt(0) | bt(6), '0, ones, '0, win(2, 17));
    idle(4);
    run_seq("stretch_expiry", 0, 25, bt(0) | bt(10), '0, ones, '0, win(2, 21));
    idle(4);
    run_seq("stretch_late", 0, 25, bt(0) | bt(11), '0, ones, '0, win(2, 11) | win(13, 22));
    idle(4);

    run_seq("blink", 1, 34, bt(0) | bt(4) | bt(6), ones, ones, '0, win(2, 11) | win(16, 25));
    idle(4);

    run_seq("mode_change", 0, 52, bt(0) | bt(6) | bt(20) | bt(24), ~win(0, 3), ones, '0,
            win(2, 17) | win(22, 31) | win(36, 45));
    bus.mode[0] = 1'b0;
    idle(4);

    run_seq("enable", 0, 32, win(0, 14) | win(18, 63), '0, ~win(5, 7), '0,
            win(2, 4) | win(20, 29));
    idle(4);

    run_seq("lamp", 2, 18, bt(0), '0, ~win(13, 14), win(4, 6) | win(12, 14), win(2, 11));
    idle(4);

    run_seq("rst_on", 3, 6, bt(0) | bt(4), ones, ones, '0, win(2, 11));
    #2 reset_n = 1'b0;
    #1 check("rst_on_async", bus.out, 4'h0);
    step();
    reset_n = 1'b1;
    run_seq("rst_on_after", 3, 20, '0, ones, ones, '0, '0);
    run_seq("rst_gap", 3, 14, bt(0) | bt(4), ones, ones, '0, win(2, 11));
    #2 reset_n = 1'b0;
    #1 check("rst_gap_async", bus.out, 4'h0);
    step();
    reset_n = 1'b1;
    run_seq("rst_gap_after", 3, 20, '0, ones, ones, '0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
